// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory arbiter: default widths,
// hold limit and the FSM state encoding.
package mem_arb_pkg;

    localparam int ARB_AW       = 32;
    localparam int ARB_DW       = 32;
    localparam int ARB_MAX_HOLD = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester channel of the memory arbiter (a read-modify-write sequencer).
//
// Handshake: the master holds req (with wr_en/addr/wdata valid) until it sees gnt;
// an access completes in every cycle where req && gnt. gnt is registered, so it
// answers a req one cycle later. lock asks to keep gnt in the following cycle.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          lock;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic [DW-1:0] rdata;

    modport master (output req, lock, wr_en, addr, wdata, input gnt, rdata);
    modport slave  (input req, lock, wr_en, addr, wdata, output gnt, rdata);
endinterface

// File: rtl/mem_arb_mux.sv
// Owner-select datapath: steers the owning master onto the memory bus and
// returns read data only to the master holding the grant.
module mem_arb_mux #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          gnt0,
    input  logic          gnt1,
    input  logic          m0_req,
    input  logic          m0_wr_en,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_wr_en,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata
);

    // A master that drops req while still granted must not write.
    always_comb begin
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_wr_en = m0_wr_en & m0_req;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_wr_en = m1_wr_en & m1_req;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    assign m0_rdata = gnt0 ? mem_rdata : '0;
    assign m1_rdata = gnt1 ? mem_rdata : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for two masters sharing one single-port memory, with an
// optional lock bounded by MAX_HOLD cycles while the other master waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = ARB_AW,
    parameter int DW       = ARB_DW,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic          clk,
    input  logic          nrst,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner,
    output logic [1:0]    dbg_state
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_t    state;
    logic [HW-1:0] hold_cnt;
    logic          last_owner;
    logic          gnt0;
    logic          gnt1;

    // Grants decode straight from the state register: no req-to-gnt comb path.
    assign gnt0      = (state == ST_OWN0);
    assign gnt1      = (state == ST_OWN1);
    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign busy      = gnt0 | gnt1;
    assign owner     = gnt1;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            last_owner <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    if (m0.req && m1.req)
                        state <= last_owner ? ST_OWN0 : ST_OWN1;
                    else if (m0.req)
                        state <= ST_OWN0;
                    else if (m1.req)
                        state <= ST_OWN1;
                end
                ST_OWN0: begin
                    if (m0.req && (!m1.req || (m0.lock && hold_cnt < HOLD_LAST))) begin
                        if (hold_cnt != HOLD_LAST)
                            hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        state      <= m1.req ? ST_OWN1 : ST_IDLE;
                        last_owner <= 1'b0;
                        hold_cnt   <= '0;
                    end
                end
                ST_OWN1: begin
                    if (m1.req && (!m0.req || (m1.lock && hold_cnt < HOLD_LAST))) begin
                        if (hold_cnt != HOLD_LAST)
                            hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        state      <= m0.req ? ST_OWN0 : ST_IDLE;
                        last_owner <= 1'b1;
                        hold_cnt   <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    mem_arb_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .m0_req    (m0.req),
        .m0_wr_en  (m0.wr_en),
        .m0_addr   (m0.addr),
        .m0_wdata  (m0.wdata),
        .m1_req    (m1.req),
        .m1_wr_en  (m1.wr_en),
        .m1_addr   (m1.addr),
        .m1_wdata  (m1.wdata),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .m0_rdata  (m0.rdata),
        .m1_rdata  (m1.rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, lock/hold limit, dropped-req
// writes, async reset mid-tenure and the read-data return path.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          nrst;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem_arr [0:15];
    logic [31:0]   exp_q [$];
    int            n_cmp;
    int            n_err;

    mem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .m0        (m0_if.slave),
        .m1        (m1_if.slave),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner),
        .dbg_state (dbg_state)
    );

    // Clock and a small behavioural memory behind the arbiter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_wr_en) mem_arr[mem_addr[3:0]] <= mem_wdata;
    assign mem_rdata = mem_arr[mem_addr[3:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic lock, input logic wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m0_if.req = req; m0_if.lock = lock; m0_if.wr_en = wr;
        m0_if.addr = addr; m0_if.wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic lock, input logic wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        m1_if.req = req; m1_if.lock = lock; m1_if.wr_en = wr;
        m1_if.addr = addr; m1_if.wdata = wdata;
    endtask

    task automatic do_reset();
        set_m0(1'b0, 1'b0, 1'b0, '0, '0);
        set_m1(1'b0, 1'b0, 1'b0, '0, '0);
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset state
        do_reset();
        nrst = 1'b0;
        #1;
        chk("rst_m0_gnt", 32'(m0_if.gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_if.gnt), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_wr_en",  32'(mem_wr_en), 32'd0);
        chk("rst_addr",   mem_addr, 32'd0);
        chk("rst_wdata",  mem_wdata, 32'd0);
        chk("rst_state",  32'(dbg_state), 32'd0);
        nrst = 1'b1;

        // Single master write, then drop req with wr_en still high
        set_m0(1'b1, 1'b0, 1'b1, 32'd4, 32'h5);
        #1;
        chk("t1_no_comb_gnt", 32'(m0_if.gnt), 32'd0);
        tick();
        chk("t1_m0_gnt", 32'(m0_if.gnt), 32'd1);
        chk("t1_m1_gnt", 32'(m1_if.gnt), 32'd0);
        chk("t1_addr",   mem_addr, 32'd4);
        chk("t1_wr_en",  32'(mem_wr_en), 32'd1);
        chk("t1_wdata",  mem_wdata, 32'h5);
        chk("t1_owner",  32'(owner), 32'd0);
        tick();
        chk("t1_mem4", mem_arr[4], 32'h5);
        set_m0(1'b0, 1'b0, 1'b1, 32'd4, 32'h9);
        #1;
        chk("t4_drop_wr_en", 32'(mem_wr_en), 32'd0);
        chk("t4_drop_gnt",   32'(m0_if.gnt), 32'd1);
        tick();
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_mem4_kept", mem_arr[4], 32'h5);
        chk("t4_idle_addr", mem_addr, 32'd0);

        // Both requesting, no lock: strict alternation starting with m0
        do_reset();
        set_m0(1'b1, 1'b0, 1'b0, 32'd1, 32'h0);
        set_m1(1'b1, 1'b0, 1'b0, 32'd2, 32'h0);
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 32'd1 : 32'd2);
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            tick();
            chk("t2_gnt_vec", {30'd0, m1_if.gnt, m0_if.gnt}, e);
            chk("t2_busy",    32'(busy), 32'd1);
            chk("t2_addr",    mem_addr, e);
        end

        // Lock held by m0 against a waiting m1: exactly 8 cycles
        do_reset();
        set_m0(1'b1, 1'b1, 1'b0, 32'd0, 32'h0);
        set_m1(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_m0_hold", 32'(m0_if.gnt), 32'd1);
        end
        tick();
        chk("t3_m0_forced_off", 32'(m0_if.gnt), 32'd0);
        chk("t3_m1_gnt",        32'(m1_if.gnt), 32'd1);

        // Owner drops req as the other raises it: direct handover
        do_reset();
        set_m0(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
        tick();
        chk("t4b_m0_gnt", 32'(m0_if.gnt), 32'd1);
        set_m0(1'b0, 1'b0, 1'b1, 32'd6, 32'h77);
        set_m1(1'b1, 1'b0, 1'b0, 32'd3, 32'h0);
        #1;
        chk("t4b_drop_wr_en", 32'(mem_wr_en), 32'd0);
        tick();
        chk("t4b_m1_gnt", 32'(m1_if.gnt), 32'd1);
        chk("t4b_busy",   32'(busy), 32'd1);
        chk("t4b_owner",  32'(owner), 32'd1);

        // m1 locked and writing; reset mid-tenure withdraws everything at once
        set_m1(1'b1, 1'b1, 1'b1, 32'd3, 32'h33);
        set_m0(1'b1, 1'b0, 1'b0, 32'd2, 32'h0);
        tick();
        chk("t5_m1_locked", 32'(m1_if.gnt), 32'd1);
        chk("t5_wr_en",     32'(mem_wr_en), 32'd1);
        nrst = 1'b0;
        #1;
        chk("t5_rst_m1_gnt", 32'(m1_if.gnt), 32'd0);
        chk("t5_rst_busy",   32'(busy), 32'd0);
        chk("t5_rst_wr_en",  32'(mem_wr_en), 32'd0);
        tick();
        tick();
        nrst = 1'b1;
        tick();
        chk("t5_m0_first", 32'(m0_if.gnt), 32'd1);
        chk("t5_m1_after", 32'(m1_if.gnt), 32'd0);

        // Read path: m1 writes addr 8, then reads it back
        do_reset();
        set_m1(1'b1, 1'b0, 1'b1, 32'd8, 32'h80000001);
        set_m0(1'b0, 1'b0, 1'b0, 32'd5, 32'h0);
        tick();
        chk("t6_m1_gnt", 32'(m1_if.gnt), 32'd1);
        tick();
        set_m1(1'b1, 1'b0, 1'b0, 32'd8, 32'h0);
        #1;
        chk("t6_m1_rdata", m1_if.rdata, 32'h80000001);
        chk("t6_m0_rdata", m0_if.rdata, 32'h0);
        chk("t6_wr_en",    32'(mem_wr_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog in case the directed sequence stalls.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
